// File: rtl/shift_seq_ctrl.sv
// Start/ready-sequenced controller for a WIDTH-stage shift register: loads a parallel
// word, shifts it out MSB first while capturing ser_in, and pulses done on completion.
module shift_seq_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_in,
  input  logic             shift_en,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             ser_out,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [WIDTH-1:0] dout_q,    dout_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ready_q,   ready_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             ser_out_q, ser_out_d;
  logic [WIDTH-1:0] shift_word_s;

  assign shift_word_s = {shreg_q[WIDTH-2:0], ser_in};

  // Next-state, datapath and next-output decode; outputs derive from the next state so they can be flopped.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d   = din;
          bit_cnt_d = {CNT_W{1'b0}};
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (shift_en) begin
          shreg_d = shift_word_s;
          if (bit_cnt_q == LAST_CNT) begin
            dout_d    = shift_word_s;
            bit_cnt_d = {CNT_W{1'b0}};
            state_d   = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            state_d   = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d == ST_SHIFT) || (state_d == ST_DONE);
    done_d    = (state_d == ST_DONE);
    ser_out_d = (state_d == ST_SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
  end

  // State and output registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= {WIDTH{1'b0}};
      dout_q    <= {WIDTH{1'b0}};
      bit_cnt_q <= {CNT_W{1'b0}};
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ser_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      bit_cnt_q <= bit_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ser_out_q <= ser_out_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ser_out = ser_out_q;
  assign dout    = dout_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed plus randomized bench for shift_seq_ctrl, checked every cycle against a
// transfer-level reference model (word, shift count, captured serial bits).
module tb_shift_seq_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, ser_in, shift_en, abort;
  logic [W-1:0] din;
  logic         ready, busy, ser_out, done;
  logic [W-1:0] dout;
  logic [2:0]   bit_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: phase 0 idle, 1 shifting, 2 done
  int           m_phase;
  int           m_k;
  logic [W-1:0] m_word, m_cap, m_dout;

  logic         ob_ser   [0:63];
  logic         ob_done  [0:63];
  logic         ob_ready [0:63];
  logic [2:0]   ob_cnt   [0:63];
  logic [W-1:0] ob_dout  [0:63];

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .ser_in(ser_in),
    .shift_en(shift_en), .abort(abort), .ready(ready), .busy(busy),
    .ser_out(ser_out), .done(done), .dout(dout), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ser();
    return (m_phase == 1) ? m_word[W-1-m_k] : 1'b0;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_k = 0; m_dout = '0; m_word = '0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_word = din; m_k = 0; m_cap = '0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (abort) begin
        m_phase = 0;
      end else if (shift_en) begin
        m_cap = {m_cap[W-2:0], ser_in};
        m_k++;
        if (m_k == W) begin
          m_dout = m_cap; m_k = 0; m_phase = 2;
        end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_all();
    chk("ready",   ready,   m_phase == 0);
    chk("busy",    busy,    m_phase != 0);
    chk("done",    done,    m_phase == 2);
    chk("ser_out", ser_out, exp_ser());
    chk("bit_cnt", bit_cnt, m_k);
    chk("dout",    dout,    m_dout);
  endtask

  // sm: 0 ser_in=0, 1 ser_in=1, 2 loopback of ser_out, 3 random
  task automatic tick(input logic st, input logic [W-1:0] d, input logic en,
                      input logic ab, input logic r, input int sm);
    start = st; din = d; shift_en = en; abort = ab; rst = r;
    case (sm)
      0:       ser_in = 1'b0;
      1:       ser_in = 1'b1;
      2:       ser_in = exp_ser();
      default: ser_in = 1'($urandom_range(0, 1));
    endcase
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic xfer(input logic [W-1:0] d, input int sm, input int stall_lo, input int stall_hi,
                      input int abort_c, input int rst_c, input int start_c, output int done_c);
    int last_c;
    done_c = -1;
    last_c = 0;
    tick(1'b1, d, 1'b1, 1'b0, 1'b0, sm);
    for (int c = 1; c < 40; c++) begin
      ob_ser[c] = ser_out; ob_done[c] = done; ob_ready[c] = ready;
      ob_cnt[c] = bit_cnt; ob_dout[c] = dout;
      last_c = c;
      if (done === 1'b1 && done_c < 0) done_c = c;
      if (done_c >= 0 && c == done_c + 1) break;
      if ((abort_c >= 0 && c == abort_c + 1) || (rst_c >= 0 && c == rst_c + 1)) break;
      tick(c == start_c, ~d, !(c >= stall_lo && c <= stall_hi), c == abort_c, c == rst_c, sm);
    end
    chk("xfer_budget", last_c < 39, 1'b1);
  endtask

  initial begin
    int dc;
    int ndone;
    logic [W-1:0] serv, prev_dout, rd;
    start = 1'b0; din = '0; ser_in = 1'b0; shift_en = 1'b0; abort = 1'b0; rst = 1'b1;
    m_phase = 0; m_k = 0; m_word = '0; m_cap = '0; m_dout = '0;

    // 1: reset
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ser", ser_out, 1'b0);
    chk("rst_dout", dout, 8'h00);

    // 2: loopback A5
    xfer(8'hA5, 2, -1, -1, -1, -1, -1, dc);
    serv = '0;
    ndone = 0;
    for (int c = 1; c <= 8; c++) serv = {serv[W-2:0], ob_ser[c]};
    for (int c = 1; c <= 10; c++) ndone += int'(ob_done[c]);
    chk("t2_serial", serv, 8'hA5);
    chk("t2_done_cyc", dc, 9);
    chk("t2_done_cnt", ndone, 1);
    chk("t2_dout", ob_dout[9], 8'hA5);
    chk("t2_ready10", ob_ready[10], 1'b1);

    // 3: ser_in tied 1, start held through DONE, then immediate second transfer
    xfer(8'h3C, 1, -1, -1, -1, -1, 9, dc);
    chk("t3a_dout", dout, 8'hFF);
    chk("t3a_done_cyc", dc, 9);
    xfer(8'h81, 0, -1, -1, -1, -1, -1, dc);
    chk("t3b_dout", dout, 8'h00);
    chk("t3b_done_abs", dc + 10, 19);

    // 4: stall in cycles 3..5
    xfer(8'hF0, 2, 3, 5, -1, -1, -1, dc);
    for (int c = 3; c <= 5; c++) begin
      chk("t4_ser_hold", ob_ser[c], 1'b1);
      chk("t4_cnt_hold", ob_cnt[c], 3'd2);
    end
    chk("t4_done_cyc", dc, 12);
    chk("t4_dout", dout, 8'hF0);

    // 5: abort with start and shift_en in the same cycle, then restart at once
    prev_dout = dout;
    xfer(8'h5A, 2, -1, -1, 4, -1, 4, dc);
    chk("t5_no_done", dc, -1);
    chk("t5_idle5", ob_ready[5], 1'b1);
    chk("t5_dout_hold", ob_dout[5], prev_dout);
    xfer(8'h96, 2, -1, -1, -1, -1, -1, dc);
    chk("t5_restart_done", dc, 9);
    chk("t5_restart_dout", dout, 8'h96);

    // 6: ignored start mid-transfer, then reset mid-transfer
    xfer(8'hC3, 2, -1, -1, -1, -1, 3, dc);
    chk("t6_dout_first", dout, 8'hC3);
    xfer(8'h7E, 2, -1, -1, -1, 5, -1, dc);
    chk("t6_no_done", dc, -1);
    chk("t6_rst_ready", ready, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_dout", dout, 8'h00);
    chk("t6_rst_cnt", bit_cnt, 3'd0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
    chk("t6_still_idle", done, 1'b0);

    // randomized transfers against the model
    for (int t = 0; t < 30; t++) begin
      int lo, hi, ab;
      rd = W'($urandom);
      lo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : -1;
      hi = (lo >= 0) ? lo + int'($urandom_range(0, 3)) : -1;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
      xfer(rd, 3, lo, hi, ab, -1, int'($urandom_range(1, 12)), dc);
      if ($urandom_range(0, 1) == 1) tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Controller for a W-stage clocked shift-register datapath. It loads a parallel word and sequences exactly WIDTH register-to-register shifts, presenting one bit per shift on a serial output while capturing a serial input into the LSB. Flow control is a start/ready handshake with a one-cycle done pulse, plus shift stall and abort. It sits between a parallel producer or consumer and any serial link or loopback chain built from non-blocking register stages.

Parameters:
WIDTH, 8, shift-chain length and parallel word width in bits (WIDTH >= 2).
CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock; all state updates on posedge clk only.
rst  input  1  synchronous, active-high reset; sampled on posedge clk.
start  input  1  request to load din and begin a transfer; accepted only when ready=1.
din  input  WIDTH  parallel word to shift out, MSB first; sampled on the accepting edge.
ser_in  input  1  serial input shifted into shreg LSB on each shift edge.
shift_en  input  1  1 = perform a shift this edge while in SHIFT; 0 = hold.
abort  input  1  cancel the current transfer; no done is produced.
ready  output  1  1 only in IDLE.
busy  output  1  1 in SHIFT and DONE.
ser_out  output  1  shreg[WIDTH-1] while in SHIFT; 0 otherwise.
done  output  1  single-cycle pulse, high only in DONE.
dout  output  WIDTH  captured word; registered, updated on entry to DONE, held otherwise.
bit_cnt  output  CNT_W  number of shifts completed in the current transfer.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, shreg=0, bit_cnt=0, dout=0. Outputs after reset: ready=1, busy=0, done=0, ser_out=0.
- rst has priority over every other input, including mid-transfer. A transfer interrupted by rst produces no done.
- All registers are updated with non-blocking semantics. Stage order is shreg[i] <= shreg[i-1], with no same-edge fall-through.
- FSM states: IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - start=1 at an edge: shreg <= din, bit_cnt <= 0, next state SHIFT.
  - Otherwise stay in IDLE. shreg holds its value.
- SHIFT:
  - abort=1: next state IDLE. shreg, bit_cnt and dout hold. No done. abort beats shift_en.
  - abort=0 and shift_en=1: shreg <= {shreg[WIDTH-2:0], ser_in} and bit_cnt <= bit_cnt+1.
  - If bit_cnt==WIDTH-1 on that edge: dout <= {shreg[WIDTH-2:0], ser_in}, bit_cnt <= 0, next state DONE.
  - abort=0 and shift_en=0: all state holds, and ser_out keeps presenting the same bit.
- DONE: lasts exactly 1 cycle, then IDLE unconditionally. abort and shift_en are ignored in DONE.
- start is ignored whenever ready=0 (SHIFT or DONE). It is not queued. Start is re-accepted in the first cycle after DONE.
- Latency with no stalls, taking the accepting edge as the end of cycle 0:
  - bit k (din[WIDTH-1-k]) appears on ser_out in cycle k+1, for k = 0..WIDTH-1.
  - done=1 and the new dout are valid in cycle WIDTH+1.
  - ready=1 in cycle WIDTH+2.
- Each stalled cycle (shift_en=0 in SHIFT) adds exactly 1 cycle to all later events.
- bit_cnt never exceeds WIDTH-1. It wraps to 0 only via the DONE transition.
- dout changes only on entry to DONE and on rst.

Test Plan:
1. WIDTH=8, rst for 2 cycles, then idle -> ready=1, busy=0, done=0, ser_out=0, dout=8'h00.
2. start with din=8'hA5, ser_in looped back from ser_out, shift_en=1 -> ser_out over cycles 1..8 = 1,0,1,0,0,1,0,1; done pulses in cycle 9 only; dout=8'hA5; ready=1 in cycle 10.
3. din=8'h3C, ser_in tied 1 -> dout=8'hFF. Then an immediate second start with din=8'h81 and ser_in tied 0 -> dout=8'h00; the second transfer is accepted in cycle 10 and its done appears in cycle 19.
4. din=8'hF0 with shift_en=0 during cycles 3-5 -> ser_out holds 1 through the stall; done in cycle 12; bit_cnt stays at 2 during the stall.
5. abort=1 in cycle 4, with shift_en=1 and start=1 both asserted in that same cycle -> IDLE in cycle 5; no done; dout unchanged from the previous transfer; a start in cycle 5 is accepted.
6. rst asserted in cycle 5 of a transfer -> cycle 6 shows the full reset values (dout=8'h00) and no done ever pulses; start during SHIFT (cycle 3) is ignored, so dout reflects only the first din.
